// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: mem_op_t encoding, FSM states
// and access-class predicates used by mem_stage and load_align.
package mem_stage_pkg;

    localparam int XLEN_W = 32;
    localparam int RD_W_W = 5;
    localparam int OP_W   = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LH   = 4'd2,
        OP_LW   = 4'd3,
        OP_LBU  = 4'd4,
        OP_LHU  = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT_R = 2'd2
    } state_t;

    function automatic logic is_load(input mem_op_t op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_half(input mem_op_t op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic is_word(input mem_op_t op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_misaligned(input mem_op_t op,
                                           input logic [1:0] off);
        return (is_half(op) && off[0]) || (is_word(op) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: picks the byte/half at the access offset out of the
// returned word and sign- or zero-extends it to XLEN.
module load_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = XLEN_W
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      off_i,
    input  mem_op_t         op_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  b_sel;
    logic [15:0] h_sel;

    always_comb begin
        b_sel  = rdata_i[{off_i, 3'b000} +: 8];
        h_sel  = rdata_i[{off_i[1], 4'b0000} +: 16];
        data_o = rdata_i;
        unique case (1'b1)
            (op_i == OP_LB):  data_o = {{(XLEN-8){b_sel[7]}}, b_sel};
            (op_i == OP_LBU): data_o = {{(XLEN-8){1'b0}}, b_sel};
            (op_i == OP_LH):  data_o = {{(XLEN-16){h_sel[15]}}, h_sel};
            (op_i == OP_LHU): data_o = {{(XLEN-16){1'b0}}, h_sel};
            default:          data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store over a req/gnt/rvalid port, one WB beat per op.
// Optional MEM_MISALIGN_TRAP_EN adds EXC_MISALIGN instead of masking offsets.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN = XLEN_W,
    parameter int RD_W = RD_W_W
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [3:0]      IN_OP,
    input  logic [XLEN-1:0] IN_RESULT,
    input  logic [XLEN-1:0] IN_STORE_VAL,
    input  logic [RD_W-1:0] IN_RD,
    output logic            DMEM_REQ,
    output logic            DMEM_WE,
    output logic [XLEN-1:0] DMEM_ADDR,
    output logic [XLEN-1:0] DMEM_WDATA,
    output logic [3:0]      DMEM_WSTRB,
    input  logic            DMEM_GNT,
    input  logic            DMEM_RVALID,
    input  logic [XLEN-1:0] DMEM_RDATA,
    output logic            WB_VALID,
    output logic [RD_W-1:0] WB_RD,
    output logic [XLEN-1:0] WB_DATA
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic            EXC_MISALIGN
`endif
);

    state_t          state_q;
    mem_op_t         op_q;
    logic [1:0]      off_q;
    logic [RD_W-1:0] rd_q;
    logic            req_q;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      wstrb_q;
    logic            wb_valid_q;
    logic [RD_W-1:0] wb_rd_q;
    logic [XLEN-1:0] wb_data_q;

    mem_op_t         op_in;
    logic [1:0]      off_d;
    logic [3:0]      wstrb_d;
    logic [XLEN-1:0] wdata_d;
    logic            trap;
    logic            is_mem;
    logic [XLEN-1:0] ld_data;

    // Offsets are masked down to the access width when not trapping.
    always_comb begin
        op_in   = mem_op_t'(IN_OP);
        is_mem  = is_load(op_in) || is_store(op_in);
        off_d   = IN_RESULT[1:0];
        if (is_word(op_in)) begin
            off_d = 2'b00;
        end else if (is_half(op_in)) begin
            off_d[0] = 1'b0;
        end
        wstrb_d = 4'h0;
        wdata_d = IN_STORE_VAL;
        unique case (1'b1)
            (op_in == OP_SB): begin
                wstrb_d = 4'b0001 << off_d;
                wdata_d = XLEN'({4{IN_STORE_VAL[7:0]}});
            end
            (op_in == OP_SH): begin
                wstrb_d = 4'b0011 << off_d;
                wdata_d = XLEN'({2{IN_STORE_VAL[15:0]}});
            end
            (op_in == OP_SW): wstrb_d = 4'hF;
            default: ;
        endcase
`ifdef MEM_MISALIGN_TRAP_EN
        trap = is_misaligned(op_in, IN_RESULT[1:0]);
`else
        trap = 1'b0;
`endif
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata_i (DMEM_RDATA),
        .off_i   (off_q),
        .op_i    (op_q),
        .data_o  (ld_data)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    logic exc_q;
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            exc_q <= 1'b0;
        end else begin
            exc_q <= (state_q == S_IDLE) && IN_VALID && trap;
        end
    end
    assign EXC_MISALIGN = exc_q;
`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= S_IDLE;
            op_q       <= OP_NONE;
            off_q      <= 2'b00;
            rd_q       <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= 4'h0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (IN_VALID && !trap) begin
                        if (is_mem) begin
                            op_q    <= op_in;
                            off_q   <= off_d;
                            rd_q    <= IN_RD;
                            req_q   <= 1'b1;
                            we_q    <= is_store(op_in);
                            addr_q  <= {IN_RESULT[XLEN-1:2], 2'b00};
                            wdata_q <= wdata_d;
                            wstrb_q <= wstrb_d;
                            state_q <= S_REQ;
                        end else if (IN_RD != '0) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= IN_RD;
                            wb_data_q  <= IN_RESULT;
                        end
                    end
                end
                S_REQ: begin
                    if (DMEM_GNT) begin
                        req_q   <= 1'b0;
                        state_q <= we_q ? S_IDLE : S_WAIT_R;
                    end
                end
                S_WAIT_R: begin
                    if (DMEM_RVALID) begin
                        if (rd_q != '0) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= rd_q;
                            wb_data_q  <= ld_data;
                        end
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Memory contract: read data never returns in the grant cycle.
    a_no_rvalid_with_gnt: assert property (
        @(posedge CLK) disable iff (!RSTN) !(DMEM_GNT && DMEM_RVALID)
    );

    assign IN_READY   = (state_q == S_IDLE);
    assign DMEM_REQ   = req_q;
    assign DMEM_WE    = we_q;
    assign DMEM_ADDR  = addr_q;
    assign DMEM_WDATA = wdata_q;
    assign DMEM_WSTRB = wstrb_q;
    assign WB_VALID   = wb_valid_q;
    assign WB_RD      = wb_rd_q;
    assign WB_DATA    = wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus random ops
// compared against a behavioural model of the load/store rules.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        CLK;
    logic        RSTN;
    logic        IN_VALID;
    logic        IN_READY;
    logic [3:0]  IN_OP;
    logic [31:0] IN_RESULT;
    logic [31:0] IN_STORE_VAL;
    logic [4:0]  IN_RD;
    logic        DMEM_REQ;
    logic        DMEM_WE;
    logic [31:0] DMEM_ADDR;
    logic [31:0] DMEM_WDATA;
    logic [3:0]  DMEM_WSTRB;
    logic        DMEM_GNT;
    logic        DMEM_RVALID;
    logic [31:0] DMEM_RDATA;
    logic        WB_VALID;
    logic [4:0]  WB_RD;
    logic [31:0] WB_DATA;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        EXC_MISALIGN;
`endif

    int checks = 0;
    int passes = 0;

    mem_stage dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .IN_VALID     (IN_VALID),
        .IN_READY     (IN_READY),
        .IN_OP        (IN_OP),
        .IN_RESULT    (IN_RESULT),
        .IN_STORE_VAL (IN_STORE_VAL),
        .IN_RD        (IN_RD),
        .DMEM_REQ     (DMEM_REQ),
        .DMEM_WE      (DMEM_WE),
        .DMEM_ADDR    (DMEM_ADDR),
        .DMEM_WDATA   (DMEM_WDATA),
        .DMEM_WSTRB   (DMEM_WSTRB),
        .DMEM_GNT     (DMEM_GNT),
        .DMEM_RVALID  (DMEM_RVALID),
        .DMEM_RDATA   (DMEM_RDATA),
        .WB_VALID     (WB_VALID),
        .WB_RD        (WB_RD),
        .WB_DATA      (WB_DATA)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .EXC_MISALIGN (EXC_MISALIGN)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic bit m_is_load(input mem_op_t op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic bit m_is_store(input mem_op_t op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic bit m_misaligned(input mem_op_t op, input int a);
        if (op inside {OP_LH, OP_LHU, OP_SH}) return (a % 2) != 0;
        if (op inside {OP_LW, OP_SW}) return (a % 4) != 0;
        return 0;
    endfunction

    function automatic logic [31:0] m_load(input mem_op_t op,
                                           input logic [31:0] a,
                                           input logic [31:0] w);
        int off;
        int unsigned v;
        off = int'(a % 4);
        case (op)
            OP_LB, OP_LBU: begin
                v = (w >> (8 * off)) % 256;
                if (op == OP_LB && v >= 128) return 32'(int'(v) - 256);
                return v;
            end
            OP_LH, OP_LHU: begin
                v = (w >> (8 * (off - off % 2))) % 65536;
                if (op == OP_LH && v >= 32768) return 32'(int'(v) - 65536);
                return v;
            end
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] m_strb(input mem_op_t op,
                                          input logic [31:0] a);
        int off;
        off = int'(a % 4);
        case (op)
            OP_SB:   return 4'(1 << off);
            OP_SH:   return 4'(3 << (off - off % 2));
            OP_SW:   return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input mem_op_t op,
                                            input logic [31:0] s);
        case (op)
            OP_SB:   return (s % 256) * 32'h0101_0101;
            OP_SH:   return (s % 65536) * 32'h0001_0001;
            default: return s;
        endcase
    endfunction

    task automatic run_op(input mem_op_t op, input logic [31:0] a,
                          input logic [31:0] sval, input logic [4:0] rd,
                          input int gdly, input int rdly,
                          input logic [31:0] rdata);
        bit ld;
        bit st;
        ld = m_is_load(op);
        st = m_is_store(op);
        @(negedge CLK);
        chk("ready_before", IN_READY, 1);
        IN_VALID = 1'b1;
        IN_OP = op;
        IN_RESULT = a;
        IN_STORE_VAL = sval;
        IN_RD = rd;
        @(negedge CLK);
        IN_VALID = 1'b0;
        IN_OP = 4'($urandom_range(0, 8));
`ifdef MEM_MISALIGN_TRAP_EN
        if ((ld || st) && m_misaligned(op, int'(a % 4))) begin
            chk("exc_pulse", EXC_MISALIGN, 1);
            chk("exc_no_req", DMEM_REQ, 0);
            chk("exc_no_wb", WB_VALID, 0);
            chk("exc_ready", IN_READY, 1);
            @(negedge CLK);
            chk("exc_one_cycle", EXC_MISALIGN, 0);
            return;
        end
`endif
        if (!ld && !st) begin
            chk("none_wb_valid", WB_VALID, rd != 0);
            if (rd != 0) begin
                chk("none_wb_rd", WB_RD, rd);
                chk("none_wb_data", WB_DATA, a);
            end
            return;
        end
        chk("mem_ready_low", IN_READY, 0);
        chk("req_up", DMEM_REQ, 1);
        chk("req_we", DMEM_WE, st);
        chk("req_addr", DMEM_ADDR, a & 32'hFFFF_FFFC);
        chk("req_wstrb", DMEM_WSTRB, m_strb(op, a));
        if (st) chk("req_wdata", DMEM_WDATA, m_wdata(op, sval));
        for (int i = 0; i < gdly; i++) begin
            @(negedge CLK);
            chk("req_held", DMEM_REQ, 1);
            chk("req_addr_hold", DMEM_ADDR, a & 32'hFFFF_FFFC);
            chk("req_wstrb_hold", DMEM_WSTRB, m_strb(op, a));
            if (st) chk("req_wdata_hold", DMEM_WDATA, m_wdata(op, sval));
        end
        DMEM_GNT = 1'b1;
        @(negedge CLK);
        DMEM_GNT = 1'b0;
        chk("req_drop", DMEM_REQ, 0);
        if (st) begin
            chk("store_no_wb", WB_VALID, 0);
            chk("store_ready", IN_READY, 1);
            return;
        end
        chk("load_wait_ready", IN_READY, 0);
        for (int i = 1; i < rdly; i++) begin
            @(negedge CLK);
            chk("load_wait_ready", IN_READY, 0);
            chk("load_wait_no_wb", WB_VALID, 0);
        end
        DMEM_RVALID = 1'b1;
        DMEM_RDATA = rdata;
        @(negedge CLK);
        DMEM_RVALID = 1'b0;
        DMEM_RDATA = $urandom;
        chk("load_wb_valid", WB_VALID, rd != 0);
        if (rd != 0) begin
            chk("load_wb_rd", WB_RD, rd);
            chk("load_wb_data", WB_DATA, m_load(op, a, rdata));
        end
        chk("load_ready_back", IN_READY, 1);
    endtask

    initial begin
        logic [31:0] vals [3];
        logic [4:0]  rds [3];
        mem_op_t     op;
        logic [4:0]  rd;

        RSTN = 1'b0;
        IN_VALID = 1'b0;
        IN_OP = 4'd0;
        IN_RESULT = '0;
        IN_STORE_VAL = '0;
        IN_RD = '0;
        DMEM_GNT = 1'b0;
        DMEM_RVALID = 1'b0;
        DMEM_RDATA = '0;
        repeat (2) @(negedge CLK);
        chk("rst_ready", IN_READY, 1);
        chk("rst_req", DMEM_REQ, 0);
        chk("rst_we", DMEM_WE, 0);
        chk("rst_addr", DMEM_ADDR, 0);
        chk("rst_wdata", DMEM_WDATA, 0);
        chk("rst_wstrb", DMEM_WSTRB, 0);
        chk("rst_wb_valid", WB_VALID, 0);
        chk("rst_wb_rd", WB_RD, 0);
        chk("rst_wb_data", WB_DATA, 0);
        RSTN = 1'b1;

        run_op(OP_NONE, 32'h1234_5678, 0, 5'd5, 0, 1, 0);

        vals[0] = 32'hDEAD_BEEF; rds[0] = 5'd1;
        vals[1] = 32'h0000_0001; rds[1] = 5'd31;
        vals[2] = 32'hCAFE_F00D; rds[2] = 5'd7;
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            IN_VALID = 1'b1;
            IN_OP = OP_NONE;
            IN_RESULT = vals[i];
            IN_RD = rds[i];
            @(negedge CLK);
            chk("b2b_valid", WB_VALID, 1);
            chk("b2b_rd", WB_RD, rds[i]);
            chk("b2b_data", WB_DATA, vals[i]);
            chk("b2b_ready", IN_READY, 1);
        end
        IN_VALID = 1'b0;
        @(negedge CLK);
        chk("b2b_end", WB_VALID, 0);

        run_op(OP_NONE, 32'h5555_AAAA, 0, 5'd0, 0, 1, 0);
        run_op(OP_LB, 32'h103, 0, 5'd9, 0, 2, 32'h80FF_0000);
        run_op(OP_LHU, 32'h102, 0, 5'd10, 0, 1, 32'h8001_0000);
        run_op(OP_SB, 32'h201, 32'h0000_00AB, 5'd3, 3, 1, 0);
        run_op(OP_SH, 32'h302, 32'h1234_BEEF, 5'd0, 1, 1, 0);
        run_op(OP_LW, 32'h400, 0, 5'd0, 1, 2, 32'h1357_9BDF);
        run_op(OP_LH, 32'h502, 0, 5'd4, 2, 3, 32'hF00F_0000);

        @(negedge CLK);
        IN_VALID = 1'b1;
        IN_OP = OP_LW;
        IN_RESULT = 32'h600;
        IN_RD = 5'd12;
        @(negedge CLK);
        IN_VALID = 1'b0;
        DMEM_GNT = 1'b1;
        @(negedge CLK);
        DMEM_GNT = 1'b0;
        chk("mid_wait_ready", IN_READY, 0);
        RSTN = 1'b0;
        #1;
        chk("mid_rst_ready", IN_READY, 1);
        chk("mid_rst_req", DMEM_REQ, 0);
        chk("mid_rst_addr", DMEM_ADDR, 0);
        chk("mid_rst_wstrb", DMEM_WSTRB, 0);
        chk("mid_rst_wb", WB_VALID, 0);
        @(negedge CLK);
        RSTN = 1'b1;
        DMEM_RVALID = 1'b1;
        DMEM_RDATA = 32'hFFFF_FFFF;
        @(negedge CLK);
        DMEM_RVALID = 1'b0;
        chk("late_rvalid_no_wb", WB_VALID, 0);
        chk("late_rvalid_wb_data", WB_DATA, 0);
        chk("late_rvalid_ready", IN_READY, 1);
        chk("late_rvalid_req", DMEM_REQ, 0);

`ifdef MEM_MISALIGN_TRAP_EN
        run_op(OP_LW, 32'h102, 0, 5'd6, 0, 1, 0);
        run_op(OP_SH, 32'h103, 32'hAAAA, 5'd0, 0, 1, 0);
`else
        run_op(OP_LW, 32'h102, 0, 5'd6, 0, 1, 32'h89AB_CDEF);
        run_op(OP_SH, 32'h103, 32'h0000_5AA5, 5'd0, 0, 1, 0);
        run_op(OP_LH, 32'h701, 0, 5'd8, 0, 1, 32'h1234_8765);
`endif

        for (int n = 0; n < 60; n++) begin
            op = mem_op_t'($urandom_range(0, 8));
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            run_op(op, $urandom, $urandom, rd,
                   $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Pipeline stage directly downstream of the executer. It consumes the registered ALU result, the store operand and the memory-op/rd control, and performs loads and stores over a req/gnt/rvalid data-memory port. It delivers a single write-back beat (rd, data) to the register file. Non-memory ops pass through with 1-cycle latency. IN_READY stalls the executer while a memory transaction is outstanding.

Parameters:
XLEN, 32, datapath and address width
RD_W, 5, destination register index width

Ports:
CLK  in  1  clock; all state updates on rising edge
RSTN  in  1  asynchronous active-low reset
IN_VALID  in  1  executer presents an op this cycle
IN_READY  out  1  stage accepts op; transfer when IN_VALID&IN_READY
IN_OP  in  4  mem_op_t: NONE, LB, LH, LW, LBU, LHU, SB, SH, SW
IN_RESULT  in  XLEN  executer result; address for memory ops, data for NONE
IN_STORE_VAL  in  XLEN  rs2 value for stores
IN_RD  in  RD_W  destination register; 0 = no write
DMEM_REQ  out  1  memory request; held until DMEM_GNT
DMEM_WE  out  1  1 = store
DMEM_ADDR  out  XLEN  word-aligned address (low 2 bits 0)
DMEM_WDATA  out  XLEN  store data, lane-replicated
DMEM_WSTRB  out  4  byte enables
DMEM_GNT  in  1  request accepted this cycle
DMEM_RVALID  in  1  load data valid (>=1 cycle after GNT)
DMEM_RDATA  in  XLEN  load word
WB_VALID  out  1  one-cycle write-back pulse
WB_RD  out  RD_W  write-back register
WB_DATA  out  XLEN  write-back value

Behaviour:
- Reset (async, RSTN=0): state=IDLE; IN_READY=1; DMEM_REQ=0, DMEM_WE=0, DMEM_ADDR/WDATA=0, DMEM_WSTRB=0; WB_VALID=0, WB_RD=0, WB_DATA=0. Reset mid-transaction abandons it; a late RVALID after reset is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT_R.
- IDLE, IN_READY=1. On accept: latch op, byte offset, rd, data.
  - NONE: next cycle WB_VALID=(IN_RD!=0), WB_DATA=IN_RESULT; stay IDLE (back-to-back ops, throughput 1/cycle).
  - Load/store: next state REQ, IN_READY=0.
- REQ: DMEM_REQ=1 with stable ADDR/WE/WDATA/WSTRB until DMEM_GNT.
  - Store+GNT -> IDLE, no WB beat.
  - Load+GNT -> WAIT_R.
- WAIT_R: on DMEM_RVALID, extract byte/half at latched offset and sign-extend (LB/LH) or zero-extend (LBU/LHU). WB_VALID pulses the next cycle; -> IDLE.
- RVALID in the same cycle as GNT is illegal (memory contract); assert in simulation.
- Store lanes:
  - SB: WSTRB=1<<off, WDATA={4{byte}}.
  - SH: WSTRB=3<<off, WDATA={2{half}}.
  - SW: WSTRB=4'hF.
- IN_RD=0 never produces WB_VALID.
- Misaligned (half off[0]=1, word off!=0) handled per optional feature.
- Minimum latencies from accept to WB_VALID: NONE 1 cycle; load with 0-wait GNT and RVALID 1 cycle after GNT = 3 cycles.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined: adds output EXC_MISALIGN (1 bit, reset 0). A misaligned load/store pulses EXC_MISALIGN for one cycle after accept. No DMEM_REQ is issued, no WB beat is produced, and the stage stays IDLE.
- Undefined: low address bits are ignored for the misaligned access width (offset forced to 0 for words, bit0 cleared for halves), and the access proceeds normally.

Decomposition:
- Shared package def.sv: mem_op_t enum, helper predicates is_load/is_store, width constants.
- Sub-module load_align: combinational extract/extend from (rdata, offset, op).
- Store lane/strobe logic stays inline in mem_stage.

Test Plan:
- NONE op, IN_RESULT=32'h1234_5678, rd=5 -> next cycle WB_VALID=1, WB_RD=5, WB_DATA=32'h1234_5678; 3 back-to-back ops produce 3 consecutive pulses.
- LB addr=0x103, RDATA=0x80FF_0000, GNT immediate, RVALID 2 cycles later -> DMEM_ADDR=0x100, WB_DATA=0xFFFF_FF80; IN_READY low from accept until the WB cycle.
- LHU addr=0x102, RDATA=0x8001_0000 -> WB_DATA=0x0000_8001.
- SB addr=0x201 val=0xAB, GNT delayed 3 cycles -> DMEM_REQ held 4 cycles with stable WSTRB=4'b0010, WDATA=0xABAB_ABAB; no WB_VALID.
- LW with rd=0 -> memory read completes, WB_VALID stays 0.
- Reset asserted in WAIT_R, then RVALID arrives -> outputs at reset values, no WB beat. With MEM_MISALIGN_TRAP_EN, LW addr=0x102 -> EXC_MISALIGN pulse, no DMEM_REQ.
